cflow_redirect_ctrl: RTL and testbench
======================================

// Module: cflow_redirect_ctrl
// PURPOSE
//  Sequences recovery after a control-flow mispredict reported by the EX-stage branch unit.
//  Captures the correct PC, flushes the younger IF/ID/EX stages and holds a PC redirect to fetch
//  until fetch accepts it. Then kills in-flight fetch returns for a fixed bubble window.
//  Also registers the predictor update record and keeps branch/mispredict counters.
// PARAMETERS
//  BUBBLE_CYCLES  2   cycles flush stays high after redirect acceptance (0 = none)
//  CNT_W          32  width of the saturating performance counters
// PORTS
//  clk             in   1      core clock, all state on posedge
//  start           in   1      reset, asynchronous, active-low (start=0 -> reset)
//  cflow_valid     in   1      branch unit: resolving instr is branch/JAL/JALR
//  cflow_taken     in   1      branch unit: resolved direction
//  mispredict      in   1      branch unit: direction or target wrong
//  pc_jump         in   32     branch unit: resolved target (bit0 already cleared)
//  pc_cur          in   32     PC of the resolving instr, aligned with branch-unit outputs
//  redirect_ready  in   1      fetch accepts redirect this cycle
//  flush           out  1      kill IF/ID/EX younger instrs
//  redirect_valid  out  1      redirect request to fetch
//  redirect_pc     out  32     PC fetch must restart at
//  busy            out  1      state != S_IDLE
//  upd_valid       out  1      predictor update strobe (registered)
//  upd_pc          out  32     PC of the updated branch
//  upd_target      out  32     resolved target
//  upd_taken       out  1      resolved direction
//  branch_cnt      out  CNT_W  accepted cflow_valid events, saturating
//  mispred_cnt     out  CNT_W  accepted mispredicts, saturating
// BEHAVIOUR
//  Reset (start=0, async): state=S_IDLE, bubble count=0, all outputs 0, both counters 0.
//  accept = cflow_valid && state==S_IDLE. Inputs outside S_IDLE are wrong-path and ignored.
//  FSM states:
//   S_IDLE:
//    - on accept && mispredict: latch redirect_pc, go to S_REDIRECT.
//    - redirect_pc = cflow_taken ? pc_jump : pc_cur+32'd4 (mod 2^32, wraps).
//    - flush is asserted combinationally in this same cycle.
//   S_REDIRECT:
//    - redirect_valid=1, flush=1; redirect_pc is held stable.
//    - on redirect_ready: go to S_BUBBLE with count=BUBBLE_CYCLES-1, or to S_IDLE if BUBBLE_CYCLES==0.
//   S_BUBBLE:
//    - flush=1, redirect_valid=0.
//    - count decrements each cycle; at 0, go to S_IDLE.
//  flush  = (state==S_IDLE && accept && mispredict) || state!=S_IDLE.
//  Latency: mispredict at cycle t -> flush at t, redirect_valid from t+1.
//   - Earliest acceptance is at t+1. After acceptance at cycle a, back in S_IDLE at a+1+BUBBLE_CYCLES.
//  redirect_ready outside S_REDIRECT has no effect.
//  Predictor update, registered:
//   - upd_valid<=accept; upd_pc<=pc_cur; upd_target<=pc_jump; upd_taken<=cflow_taken.
//   - Fields hold their last value when upd_valid=0.
//  Counters:
//   - branch_cnt +1 on accept; mispred_cnt +1 on accept&&mispredict.
//   - Both saturate at all-ones and never wrap.
//  Simultaneous events:
//   - A mispredict in the cycle fetch accepts a redirect is ignored (state!=S_IDLE).
//   - A saturated counter holds while the other keeps counting.
//  Reset mid-operation: an async reset drops redirect_valid/flush immediately; no redirect is replayed.
// STRUCTURE
//  riscv_defines: add redirect_state_t {S_IDLE,S_REDIRECT,S_BUBBLE} and PC_STEP=32'd4.
//  Sub-module sat_counter #(W): clk, start, inc -> cnt; instantiated twice.
//  The FSM, the redirect PC register and the update register live in this module.
// TESTING
//  1 Reset: start=0 mid-S_REDIRECT -> flush=0, redirect_valid=0, busy=0, counters=0 immediately.
//  2 Taken mispredict, pc_jump=0x100, redirect_ready=1 at t+1:
//    flush high t..t+3, redirect_pc=0x100 at t+1, busy low at t+4 (BUBBLE_CYCLES=2).
//  3 Not-taken mispredict, pc_cur=0xFFFF_FFFC -> redirect_pc=0x0000_0000 (wrap).
//  4 Stalled fetch: redirect_ready=0 for 5 cycles -> redirect_valid and redirect_pc stable all 5.
//    Extra mispredict pulses ignored: mispred_cnt +1 only.
//  5 Correct predictions: 10 cflow_valid, mispredict=0 -> branch_cnt=10, mispred_cnt=0, flush never high.
//    upd_valid one cycle after each.
//  6 CNT_W=4: 20 mispredicts -> both counters stick at 4'hF.

Source files
------------

// File: rtl/riscv_defines.sv
// Shared definitions for the control-flow recovery logic.
//   redirect_state_t : recovery sequencer states
//   PC_STEP          : fall-through increment for a not-taken branch
package riscv_defines;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REDIRECT,
      S_BUBBLE
   } redirect_state_t;

   localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the branch / mispredict statistics.
//   clk   : clock, state on posedge
//   start : asynchronous active-low reset
//   inc   : count one event this cycle
//   cnt   : current count, sticks at all-ones
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         start,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk or negedge start) begin
      if (!start) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/cflow_redirect_ctrl.sv
// Mispredict recovery sequencer.
// A mispredict resolved by the branch unit flushes the younger stages in the
// same cycle, then a redirect to the correct PC is held until fetch accepts
// it, followed by BUBBLE_CYCLES of flush to drop stale fetch returns.
// Also registers the predictor update record and counts branches/mispredicts.
//   inputs : clk, start (async active-low reset), cflow_valid, cflow_taken,
//            mispredict, pc_jump, pc_cur, redirect_ready
//   outputs: flush, redirect_valid, redirect_pc, busy, upd_valid, upd_pc,
//            upd_target, upd_taken, branch_cnt, mispred_cnt
module cflow_redirect_ctrl
   import riscv_defines::*;
#(
   parameter int BUBBLE_CYCLES = 2,
   parameter int CNT_W         = 32
) (
   input  logic             clk,
   input  logic             start,
   input  logic             cflow_valid,
   input  logic             cflow_taken,
   input  logic             mispredict,
   input  logic [31:0]      pc_jump,
   input  logic [31:0]      pc_cur,
   input  logic             redirect_ready,
   output logic             flush,
   output logic             redirect_valid,
   output logic [31:0]      redirect_pc,
   output logic             busy,
   output logic             upd_valid,
   output logic [31:0]      upd_pc,
   output logic [31:0]      upd_target,
   output logic             upd_taken,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);

   localparam int CW = (BUBBLE_CYCLES > 1) ? $clog2(BUBBLE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_INIT = (BUBBLE_CYCLES == 0) ? '0 : CW'(BUBBLE_CYCLES - 1);

   redirect_state_t state_q, state_d;
   logic [CW-1:0]   bub_q, bub_d;
   logic [31:0]     rpc_q, rpc_d;
   logic            upd_valid_q, upd_taken_q;
   logic [31:0]     upd_pc_q, upd_target_q;
   logic            accept;

   // Gated by start so flush stays low while reset is held, even if the
   // branch unit is still presenting a mispredict.
   assign accept = cflow_valid && (state_q == S_IDLE) && start;

   always_comb begin
      state_d        = state_q;
      bub_d          = bub_q;
      rpc_d          = rpc_q;
      flush          = 1'b0;
      redirect_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept && mispredict) begin
               flush   = 1'b1;
               rpc_d   = cflow_taken ? pc_jump : pc_cur + PC_STEP;
               state_d = S_REDIRECT;
            end
         end
         S_REDIRECT: begin
            flush          = 1'b1;
            redirect_valid = 1'b1;
            if (redirect_ready) begin
               if (BUBBLE_CYCLES == 0) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_BUBBLE;
                  bub_d   = CNT_INIT;
               end
            end
         end
         S_BUBBLE: begin
            flush = 1'b1;
            if (bub_q == '0) state_d = S_IDLE;
            else             bub_d   = bub_q - CW'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge start) begin
      if (!start) begin
         state_q <= S_IDLE;
         bub_q   <= '0;
         rpc_q   <= '0;
      end else begin
         state_q <= state_d;
         bub_q   <= bub_d;
         rpc_q   <= rpc_d;
      end
   end

   // Update fields only load on accept so they hold between strobes.
   always_ff @(posedge clk or negedge start) begin
      if (!start) begin
         upd_valid_q  <= 1'b0;
         upd_pc_q     <= '0;
         upd_target_q <= '0;
         upd_taken_q  <= 1'b0;
      end else begin
         upd_valid_q <= accept;
         if (accept) begin
            upd_pc_q     <= pc_cur;
            upd_target_q <= pc_jump;
            upd_taken_q  <= cflow_taken;
         end
      end
   end

   sat_counter #(.W(CNT_W)) u_branch_cnt (
      .clk   (clk),
      .start (start),
      .inc   (accept),
      .cnt   (branch_cnt)
   );

   sat_counter #(.W(CNT_W)) u_mispred_cnt (
      .clk   (clk),
      .start (start),
      .inc   (accept && mispredict),
      .cnt   (mispred_cnt)
   );

   assign redirect_pc = rpc_q;
   assign busy        = (state_q != S_IDLE);
   assign upd_valid   = upd_valid_q;
   assign upd_pc      = upd_pc_q;
   assign upd_target  = upd_target_q;
   assign upd_taken   = upd_taken_q;

endmodule

// File: tb/tb_cflow_redirect_ctrl.sv
// Self-checking bench: a default instance (BUBBLE_CYCLES=2, CNT_W=32) and a
// narrow instance (BUBBLE_CYCLES=0, CNT_W=4) share clock, reset and stimulus.
module tb_cflow_redirect_ctrl;

   logic        clk, start;
   logic        cflow_valid, cflow_taken, mispredict, redirect_ready;
   logic [31:0] pc_jump, pc_cur;

   logic        flush, redirect_valid, busy, upd_valid, upd_taken;
   logic [31:0] redirect_pc, upd_pc, upd_target;
   logic [31:0] branch_cnt, mispred_cnt;

   logic        flush4, redirect_valid4, busy4, upd_valid4, upd_taken4;
   logic [31:0] redirect_pc4, upd_pc4, upd_target4;
   logic [3:0]  branch_cnt4, mispred_cnt4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] tgt;
      logic        tk;
   } upd_t;

   upd_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   cflow_redirect_ctrl dut (
      .clk(clk), .start(start), .cflow_valid(cflow_valid), .cflow_taken(cflow_taken),
      .mispredict(mispredict), .pc_jump(pc_jump), .pc_cur(pc_cur),
      .redirect_ready(redirect_ready), .flush(flush), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .busy(busy), .upd_valid(upd_valid), .upd_pc(upd_pc),
      .upd_target(upd_target), .upd_taken(upd_taken), .branch_cnt(branch_cnt),
      .mispred_cnt(mispred_cnt)
   );

   cflow_redirect_ctrl #(.BUBBLE_CYCLES(0), .CNT_W(4)) dut4 (
      .clk(clk), .start(start), .cflow_valid(cflow_valid), .cflow_taken(cflow_taken),
      .mispredict(mispredict), .pc_jump(pc_jump), .pc_cur(pc_cur),
      .redirect_ready(redirect_ready), .flush(flush4), .redirect_valid(redirect_valid4),
      .redirect_pc(redirect_pc4), .busy(busy4), .upd_valid(upd_valid4), .upd_pc(upd_pc4),
      .upd_target(upd_target4), .upd_taken(upd_taken4), .branch_cnt(branch_cnt4),
      .mispred_cnt(mispred_cnt4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and land 1 time unit past the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cflow_valid    = 1'b0;
      cflow_taken    = 1'b0;
      mispredict     = 1'b0;
      redirect_ready = 1'b0;
      pc_jump        = '0;
      pc_cur         = '0;
   endtask

   task automatic do_reset();
      start = 1'b0;
      idle_inputs();
      tick();
      tick();
      start = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %b want 0", flush); end
      n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rv got %b want 0", redirect_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_checks++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_upd got %b want 0", upd_valid); end
      n_checks++; if (branch_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_bcnt got %0d want 0", branch_cnt); end
      // Enter S_REDIRECT then pull reset asynchronously.
      cflow_valid = 1'b1; mispredict = 1'b1; cflow_taken = 1'b1; pc_jump = 32'h40; pc_cur = 32'h10;
      #1;
      n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL same_cycle_flush got %b want 1", flush); end
      tick();
      idle_inputs();
      #1;
      n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_rv got %b want 1", redirect_valid); end
      start = 1'b0;
      #1;
      n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL async_flush got %b want 0", flush); end
      n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL async_rv got %b want 0", redirect_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_busy got %b want 0", busy); end
      n_checks++; if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin n_fail++; $display("FAIL async_cnt got %0d/%0d want 0/0", branch_cnt, mispred_cnt); end
      tick();
      start = 1'b1;
      tick();
      n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL no_replay_rv got %b want 0", redirect_valid); end
   endtask

   task automatic test_taken();
      upd_t e, g;
      // cycle t
      cflow_valid = 1'b1; mispredict = 1'b1; cflow_taken = 1'b1; pc_jump = 32'h100; pc_cur = 32'h80;
      sb.push_back('{pc: 32'h80, tgt: 32'h100, tk: 1'b1});
      #1;
      n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL taken_flush_t got %b want 1", flush); end
      tick(); // t+1
      idle_inputs();
      redirect_ready = 1'b1;
      #1;
      n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL taken_flush_t1 got %b want 1", flush); end
      n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL taken_rv_t1 got %b want 1", redirect_valid); end
      n_checks++; if (redirect_pc !== 32'h100) begin n_fail++; $display("FAIL taken_rpc got %h want 00000100", redirect_pc); end
      n_checks++;
      if (upd_valid !== 1'b1 || sb.size() == 0) begin
         n_fail++; $display("FAIL taken_upd_valid got %b want 1", upd_valid);
      end else begin
         e = sb.pop_front();
         g = '{pc: upd_pc, tgt: upd_target, tk: upd_taken};
         if (g !== e) begin n_fail++; $display("FAIL taken_upd_rec got %h want %h", g, e); end
      end
      tick(); // t+2
      redirect_ready = 1'b0;
      #1;
      n_checks++; if (flush !== 1'b1 || redirect_valid !== 1'b0) begin n_fail++; $display("FAIL taken_bubble_t2 got flush=%b rv=%b want 1/0", flush, redirect_valid); end
      n_checks++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL taken_upd_pulse got %b want 0", upd_valid); end
      tick(); // t+3
      n_checks++; if (flush !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL taken_bubble_t3 got flush=%b busy=%b want 1/1", flush, busy); end
      tick(); // t+4
      n_checks++; if (flush !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL taken_idle_t4 got flush=%b busy=%b want 0/0", flush, busy); end
      n_checks++; if (branch_cnt !== 32'd1 || mispred_cnt !== 32'd1) begin n_fail++; $display("FAIL taken_cnt got %0d/%0d want 1/1", branch_cnt, mispred_cnt); end
   endtask

   task automatic test_wrap();
      cflow_valid = 1'b1; mispredict = 1'b1; cflow_taken = 1'b0; pc_jump = 32'h200; pc_cur = 32'hFFFF_FFFC;
      tick();
      idle_inputs();
      #1;
      n_checks++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_rpc got %h want 00000000", redirect_pc); end
      n_checks++; if (upd_taken !== 1'b0 || upd_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_upd got tk=%b pc=%h want 0/fffffffc", upd_taken, upd_pc); end
      redirect_ready = 1'b1;
      tick();
      redirect_ready = 1'b0;
      repeat (3) tick();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wrap_busy got %b want 0", busy); end
   endtask

   task automatic test_stall();
      logic [31:0] b0, m0;
      b0 = branch_cnt; m0 = mispred_cnt;
      cflow_valid = 1'b1; mispredict = 1'b1; cflow_taken = 1'b1; pc_jump = 32'h300; pc_cur = 32'h2F0;
      tick();
      // wrong-path mispredicts while fetch stalls
      pc_jump = 32'h999; pc_cur = 32'h888;
      for (int i = 0; i < 5; i++) begin
         cflow_valid = i[0] ? 1'b0 : 1'b1;
         #1;
         n_checks++;
         if (redirect_valid !== 1'b1 || redirect_pc !== 32'h300) begin
            n_fail++; $display("FAIL stall_hold[%0d] got rv=%b pc=%h want 1/00000300", i, redirect_valid, redirect_pc);
         end
         tick();
      end
      idle_inputs();
      #1;
      n_checks++; if (mispred_cnt !== m0 + 32'd1) begin n_fail++; $display("FAIL stall_mcnt got %0d want %0d", mispred_cnt, m0 + 32'd1); end
      n_checks++; if (branch_cnt !== b0 + 32'd1) begin n_fail++; $display("FAIL stall_bcnt got %0d want %0d", branch_cnt, b0 + 32'd1); end
      redirect_ready = 1'b1;
      tick();
      redirect_ready = 1'b0;
      repeat (3) tick();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_busy got %b want 0", busy); end
   endtask

   task automatic test_correct_pred();
      upd_t e, g;
      int   flush_seen;
      flush_seen = 0;
      do_reset();
      redirect_ready = 1'b1; // no effect outside S_REDIRECT
      for (int i = 0; i < 10; i++) begin
         cflow_valid = 1'b1; mispredict = 1'b0;
         cflow_taken = i[0];
         pc_cur      = 32'h1000 + 32'(i) * 32'd4;
         pc_jump     = 32'h2000 + 32'(i) * 32'd16;
         sb.push_back('{pc: pc_cur, tgt: pc_jump, tk: cflow_taken});
         #1;
         if (flush !== 1'b0) flush_seen++;
         tick();
         n_checks++;
         if (upd_valid !== 1'b1 || sb.size() == 0) begin
            n_fail++; $display("FAIL pred_upd_valid[%0d] got %b want 1", i, upd_valid);
         end else begin
            e = sb.pop_front();
            g = '{pc: upd_pc, tgt: upd_target, tk: upd_taken};
            if (g !== e) begin n_fail++; $display("FAIL pred_upd_rec[%0d] got %h want %h", i, g, e); end
         end
      end
      idle_inputs();
      tick();
      n_checks++; if (upd_valid !== 1'b0 || upd_pc !== 32'h1024 || upd_target !== 32'h2090) begin n_fail++; $display("FAIL pred_upd_hold got v=%b pc=%h tgt=%h want 0/00001024/00002090", upd_valid, upd_pc, upd_target); end
      n_checks++; if (flush_seen !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL pred_flush got %0d flush cycles busy=%b want 0/0", flush_seen, busy); end
      n_checks++; if (branch_cnt !== 32'd10 || mispred_cnt !== 32'd0) begin n_fail++; $display("FAIL pred_cnt got %0d/%0d want 10/0", branch_cnt, mispred_cnt); end
   endtask

   task automatic test_saturate();
      int busy_bad;
      busy_bad = 0;
      do_reset();
      // 15 correct predictions saturate branch_cnt only
      for (int i = 0; i < 15; i++) begin
         cflow_valid = 1'b1; mispredict = 1'b0;
         tick();
      end
      idle_inputs();
      #1;
      n_checks++; if (branch_cnt4 !== 4'hF || mispred_cnt4 !== 4'h0) begin n_fail++; $display("FAIL sat_pre got %h/%h want f/0", branch_cnt4, mispred_cnt4); end
      // saturated branch_cnt holds while mispred_cnt keeps counting
      for (int i = 0; i < 20; i++) begin
         cflow_valid = 1'b1; mispredict = 1'b1; cflow_taken = 1'b1; pc_jump = 32'h500;
         tick();
         idle_inputs();
         redirect_ready = 1'b1;
         tick();
         redirect_ready = 1'b0;
         if (busy4 !== 1'b0) busy_bad++;
         if (i == 2) begin
            n_checks++; if (branch_cnt4 !== 4'hF || mispred_cnt4 !== 4'h3) begin n_fail++; $display("FAIL sat_mixed got %h/%h want f/3", branch_cnt4, mispred_cnt4); end
         end
      end
      n_checks++; if (busy_bad !== 0) begin n_fail++; $display("FAIL nobubble_busy got %0d busy cycles want 0", busy_bad); end
      n_checks++; if (branch_cnt4 !== 4'hF || mispred_cnt4 !== 4'hF) begin n_fail++; $display("FAIL sat_final got %h/%h want f/f", branch_cnt4, mispred_cnt4); end
   endtask

   initial begin
      start = 1'b0;
      idle_inputs();
      test_reset();
      test_taken();
      test_wrap();
      test_stall();
      test_correct_pred();
      test_saturate();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
